// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Encodings follow RV32M funct3.
    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between pipeline control and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, opr_a, opr_b, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, op, opr_a, opr_b, flush,
        output busy, valid, result
    );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result signs and divide special cases.
module muldiv_operand_prep
    import muldiv_pkg::*;
(
    input  muldiv_op_e      op,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    output logic            neg_result,
    output logic            neg_rem,
    output logic            div_by_zero,
    output logic            div_overflow
);

    logic signed_a;
    logic signed_b;
    logic sign_a;
    logic sign_b;

    always_comb begin
        signed_a     = op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
        signed_b     = op inside {OpMul, OpMulh, OpDiv, OpRem};
        sign_a       = signed_a & opr_a[XLEN-1];
        sign_b       = signed_b & opr_b[XLEN-1];
        abs_a        = sign_a ? -opr_a : opr_a;
        abs_b        = sign_b ? -opr_b : opr_b;
        // Product sign and quotient sign share the same rule.
        neg_result   = sign_a ^ sign_b;
        neg_rem      = sign_a;
        div_by_zero  = is_div_op(op) && (opr_b == '0);
        div_overflow = (op inside {OpDiv, OpRem}) && (opr_a == INT_MIN) && (opr_b == '1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 1 bit/clock.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam int unsigned CntW = $clog2(ITERS);
    localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_in, op_q;

    logic [XLEN-1:0]   abs_a, abs_b;
    logic              neg_result, neg_rem, div_by_zero, div_overflow;
    logic              special, skip_calc;
    logic              busy, accept, step, finish;

    logic [2*XLEN-1:0] acc_q, acc_init;
    logic [XLEN-1:0]   b_q;
    logic              neg_res_q, neg_rem_q;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    logic [XLEN:0]     mul_sum, rem_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, res_final;

    assign op_in = muldiv_op_e'(bus.op);

    muldiv_operand_prep u_prep (
        .op           (op_in),
        .opr_a        (bus.opr_a),
        .opr_b        (bus.opr_b),
        .abs_a        (abs_a),
        .abs_b        (abs_b),
        .neg_result   (neg_result),
        .neg_rem      (neg_rem),
        .div_by_zero  (div_by_zero),
        .div_overflow (div_overflow)
    );

    assign special = div_by_zero | div_overflow;

`ifdef MULDIV_FAST_MUL_EN
    assign skip_calc = special | ~is_div_op(op_in);
`else
    assign skip_calc = special;
`endif

    // Special cases preload the final quotient/remainder so DONE needs no extra muxing.
    always_comb begin
        acc_init = {{XLEN{1'b0}}, abs_a};
        if (div_by_zero) begin
            acc_init = {bus.opr_a, DIV_ZERO_Q};
        end else if (div_overflow) begin
            acc_init = {{XLEN{1'b0}}, INT_MIN};
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div_op(op_in)) begin
            acc_init = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (bus.start) state_d = skip_calc ? StDone : StCalc;
                StCalc: if (cnt_q == CntLast) state_d = StDone;
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q != StIdle);
        accept = (state_q == StIdle) && bus.start && !bus.flush;
        step   = (state_q == StCalc) && !bus.flush;
        finish = (state_q == StDone) && !bus.flush;
    end

    // acc_q holds {remainder, quotient} for divide and {product_hi, multiplier} for multiply.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = rem_shift >= {1'b0, b_q};
        div_diff  = rem_shift[XLEN-1:0] - b_q;
        div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {acc_q[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            OpMul:                     res_final = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: res_final = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             res_final = quo;
            default:                   res_final = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OpMul;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= finish;
            if (accept) begin
                op_q      <= op_in;
                b_q       <= abs_b;
                neg_res_q <= neg_result & ~special;
                neg_rem_q <= neg_rem & ~special;
                acc_q     <= acc_init;
                cnt_q     <= '0;
            end else if (step) begin
                acc_q <= is_div_op(op_q) ? div_next : mul_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                result_q <= res_final;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file: consumes rdata1/rdata2 as operands and returns a 32-bit result to the writeback mux. Uses a start/busy/valid handshake so the pipeline control can stall on busy. Provides shift-add multiplication and restoring division at one bit per clock.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, 32, iteration count per operation; must equal XLEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
opr_a  input  32  rs1 operand (rdata1)
opr_b  input  32  rs2 operand (rdata2)
flush  input  1  abort the in-flight operation
busy  output  1  high while an accepted operation is not yet complete
valid  output  1  one-cycle pulse: result is valid
result  output  32  result; holds its value between valid pulses

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, valid=0, result=0, all internal registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE with start=1 and flush=0: latch op, compute operand magnitudes and result sign, counter=0, go to CALC.
  - Divide with opr_b=0: go directly to DONE.
  - DIV/REM with opr_a=0x80000000 and opr_b=0xFFFFFFFF: go directly to DONE.
- CALC: one iteration per clock; counter increments. After the 32nd iteration (counter==31), go to DONE.
- DONE: apply sign fix, register result, valid=1 for exactly one cycle, then return to IDLE.
- Latency, normal case: start sampled at edge 0. valid is high in the cycle after edge 33. Special cases: valid is high in the cycle after edge 1.
- busy=1 in CALC and DONE. busy=0 in IDLE.
- start while busy=1 is ignored. Upstream must hold the request until busy falls.
- Multiply: 64-bit accumulator, shift-add on unsigned magnitudes.
  - Signedness per op: MUL/MULH both operands signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - Negate the 64-bit product if the result sign is 1.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring algorithm on magnitudes; DIV/REM treat operands as signed.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient=0xFFFFFFFF; remainder=opr_a unmodified.
- Overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient=0x80000000; remainder=0.
- flush=1 in any state: next state IDLE. valid is not asserted and result is unchanged. flush beats start in the same cycle.
- Reset mid-operation: immediate return to reset values. No result is produced.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: the multiply ops compute the full 64-bit product in one cycle with a combinational multiplier and skip CALC. valid is high in the cycle after edge 1. Divide ops are unchanged.
- Undefined: the multiply ops use the 32-iteration shift-add path described above.

Decomposition:
- Package muldiv_pkg:
  - op enum muldiv_op_e (the 8 funct3 codes) and state enum muldiv_state_e;
  - constants XLEN=32, DIV_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- Sub-module muldiv_operand_prep, combinational: from op, opr_a and opr_b it produces abs_a, abs_b, neg_result, neg_rem, div_by_zero and div_overflow.
- The top level holds the FSM, counter, accumulator/remainder registers and the output register.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; busy high for 33 cycles; valid pulses once in the cycle after edge 33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with valid in the cycle after edge 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush during a DIV at CALC cycle 10 -> no valid; busy low next cycle; result keeps its previous value. A new start is accepted in the following cycle and completes correctly. A start issued while busy is ignored.
- rst_n dropped asynchronously mid-CALC -> busy, valid and result are 0 immediately. After release, a MUL 3 x 4 -> 12.
